// File: rtl/axis_packetizer.sv
// axis_packetizer: re-frames an AXI-Stream beat stream into packets of a
// programmed length. TUSER marks the first beat of each packet, TLAST is forced
// at the programmed length or taken from an early upstream TLAST. Beats and
// completed packets are counted. Datapath is an output register plus a
// one-entry skid buffer.
module axis_packetizer #(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int LEN_WIDTH       = 16,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_enable,
  input  logic [LEN_WIDTH-1:0]       i_pkt_len,
  input  logic                       i_cnt_clear,
  input  logic                       i_axis_tuser,
  input  logic                       i_axis_tvalid,
  output logic                       o_axis_tready,
  input  logic                       i_axis_tlast,
  input  logic [AXIS_DATA_WIDTH-1:0] i_axis_tdata,
  output logic                       o_axis_tuser,
  output logic                       o_axis_tvalid,
  input  logic                       i_axis_tready,
  output logic                       o_axis_tlast,
  output logic [AXIS_DATA_WIDTH-1:0] o_axis_tdata,
  output logic [LEN_WIDTH-1:0]       o_beat_index,
  output logic [CNT_WIDTH-1:0]       o_pkt_count,
  output logic                       o_short_err
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_IN_PKT = 1'b1
  } state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic [LEN_WIDTH-1:0]       r_len;
  logic [LEN_WIDTH-1:0]       r_beat_idx;
  logic [LEN_WIDTH-1:0]       w_beat_idx_next;
  logic [LEN_WIDTH-1:0]       w_len_eff;
  logic                       w_tag_user;
  logic                       w_tag_last;
  logic                       w_short;

  logic                       r_ready;
  logic                       r_out_valid;
  logic                       r_out_last;
  logic                       r_out_user;
  logic [AXIS_DATA_WIDTH-1:0] r_out_data;
  logic                       r_skid_valid;
  logic                       r_skid_last;
  logic                       r_skid_user;
  logic [AXIS_DATA_WIDTH-1:0] r_skid_data;
  logic [CNT_WIDTH-1:0]       r_pkt_count;
  logic                       r_short_err;

  logic                       w_in_acc;
  logic                       w_out_take;
  logic                       w_out_load;
  logic                       w_skid_next;
  logic                       w_unused_tuser;

  // Upstream TUSER carries nothing this block needs.
  assign w_unused_tuser = i_axis_tuser;

  assign w_in_acc   = i_axis_tvalid & r_ready;
  assign w_out_take = r_out_valid & i_axis_tready;
  // Output register can accept new content when empty or being drained.
  assign w_out_load = ~r_out_valid | w_out_take;
  // Skid holds a beat only when the output register is occupied and stays so.
  assign w_skid_next = w_out_load ? (r_skid_valid & w_in_acc) : (r_skid_valid | w_in_acc);

  // Framing decision for the beat presented this cycle, and FSM next state.
  always_comb begin
    w_state_next    = r_state;
    w_beat_idx_next = r_beat_idx;
    w_len_eff       = (r_state == S_IDLE) ? i_pkt_len : r_len;
    w_tag_user      = (r_state == S_IDLE);
    w_tag_last      = i_axis_tlast |
                      ((w_len_eff != '0) && (r_beat_idx == w_len_eff - LEN_WIDTH'(1)));
    w_short         = i_axis_tlast & (w_len_eff != '0) &
                      (r_beat_idx < w_len_eff - LEN_WIDTH'(1));
    if (w_in_acc) begin
      if (w_tag_last) begin
        w_state_next    = S_IDLE;
        w_beat_idx_next = '0;
      end else begin
        w_state_next    = S_IN_PKT;
        w_beat_idx_next = r_beat_idx + LEN_WIDTH'(1);
      end
    end
  end

  // FSM state, in-packet beat index and length latched at packet start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_beat_idx <= '0;
      r_len      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_beat_idx <= w_beat_idx_next;
      if (w_in_acc && (r_state == S_IDLE)) begin
        r_len <= i_pkt_len;
      end
    end
  end

  // Output register and skid buffer; skid drains into the output first to keep order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_user   <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_last  <= 1'b0;
      r_skid_user  <= 1'b0;
      r_skid_data  <= '0;
    end else begin
      if (w_out_load) begin
        if (r_skid_valid) begin
          r_out_valid <= 1'b1;
          r_out_last  <= r_skid_last;
          r_out_user  <= r_skid_user;
          r_out_data  <= r_skid_data;
        end else if (w_in_acc) begin
          r_out_valid <= 1'b1;
          r_out_last  <= w_tag_last;
          r_out_user  <= w_tag_user;
          r_out_data  <= i_axis_tdata;
        end else begin
          r_out_valid <= 1'b0;
        end
      end
      r_skid_valid <= w_skid_next;
      if (w_in_acc && (r_skid_valid || !w_out_load)) begin
        r_skid_last <= w_tag_last;
        r_skid_user <= w_tag_user;
        r_skid_data <= i_axis_tdata;
      end
    end
  end

  // Registered upstream ready: open only when enabled and the skid will be empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready <= 1'b0;
    end else begin
      r_ready <= i_enable & ~w_skid_next;
    end
  end

  // Packet counter and sticky short-packet flag; a clear overrides same-cycle events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pkt_count <= '0;
      r_short_err <= 1'b0;
    end else if (i_cnt_clear) begin
      r_pkt_count <= '0;
      r_short_err <= 1'b0;
    end else begin
      if (w_out_take && r_out_last) begin
        r_pkt_count <= r_pkt_count + CNT_WIDTH'(1);
      end
      if (w_in_acc && w_short) begin
        r_short_err <= 1'b1;
      end
    end
  end

  assign o_axis_tready = r_ready;
  assign o_axis_tvalid = r_out_valid;
  assign o_axis_tlast  = r_out_last;
  assign o_axis_tuser  = r_out_user;
  assign o_axis_tdata  = r_out_data;
  assign o_beat_index  = r_beat_idx;
  assign o_pkt_count   = r_pkt_count;
  assign o_short_err   = r_short_err;

endmodule

// File: tb/tb_axis_packetizer.sv
// tb_axis_packetizer: directed scenarios plus a randomized phase, checked
// against a transaction-level framing model (queue of expected output beats).
module tb_axis_packetizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_enable;
  logic [15:0] i_pkt_len;
  logic        i_cnt_clear;
  logic        i_axis_tuser;
  logic        i_axis_tvalid;
  logic        o_axis_tready;
  logic        i_axis_tlast;
  logic [31:0] i_axis_tdata;
  logic        o_axis_tuser;
  logic        o_axis_tvalid;
  logic        i_axis_tready;
  logic        o_axis_tlast;
  logic [31:0] o_axis_tdata;
  logic [15:0] o_beat_index;
  logic [31:0] o_pkt_count;
  logic        o_short_err;

  axis_packetizer #(.AXIS_DATA_WIDTH(32), .LEN_WIDTH(16), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_pkt_len(i_pkt_len),
    .i_cnt_clear(i_cnt_clear), .i_axis_tuser(i_axis_tuser),
    .i_axis_tvalid(i_axis_tvalid), .o_axis_tready(o_axis_tready),
    .i_axis_tlast(i_axis_tlast), .i_axis_tdata(i_axis_tdata),
    .o_axis_tuser(o_axis_tuser), .o_axis_tvalid(o_axis_tvalid),
    .i_axis_tready(i_axis_tready), .o_axis_tlast(o_axis_tlast),
    .o_axis_tdata(o_axis_tdata), .o_beat_index(o_beat_index),
    .o_pkt_count(o_pkt_count), .o_short_err(o_short_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic        u;
  } beat_t;

  beat_t       q[$];
  logic        m_inpkt;
  logic [15:0] m_pos;
  logic [15:0] m_len;
  logic [31:0] m_cnt;
  logic        m_err;
  logic        m_rdy;

  // Outputs are sampled at negedge; inputs seen here are the ones the next posedge acts on.
  always @(negedge clk) begin
    beat_t b;
    logic  take, acc, last, short_p;
    logic [31:0] nxt_cnt;
    if (rst) begin
      q.delete();
      m_inpkt = 1'b0; m_pos = '0; m_len = '0;
      m_cnt = '0; m_err = 1'b0; m_rdy = 1'b0;
    end else begin
      check("tready", 32'(o_axis_tready), 32'(m_rdy));
      check("tvalid", 32'(o_axis_tvalid), 32'(q.size() != 0));
      check("beat_index", 32'(o_beat_index), 32'(m_pos));
      check("pkt_count", o_pkt_count, m_cnt);
      check("short_err", 32'(o_short_err), 32'(m_err));
      take    = o_axis_tvalid & i_axis_tready;
      acc     = i_axis_tvalid & o_axis_tready;
      nxt_cnt = m_cnt;
      if (take) begin
        if (q.size() == 0) begin
          check("spurious_take", 32'(q.size()), 32'd1);
        end else begin
          b = q.pop_front();
          check("tdata", o_axis_tdata, b.d);
          check("tlast", 32'(o_axis_tlast), 32'(b.l));
          check("tuser", 32'(o_axis_tuser), 32'(b.u));
          if (b.l) nxt_cnt = nxt_cnt + 1;
        end
      end
      if (acc) begin
        if (!m_inpkt) m_len = i_pkt_len;
        last    = i_axis_tlast || ((m_len != 0) && (m_pos == m_len - 16'd1));
        short_p = i_axis_tlast && (m_len != 0) && ((32'(m_pos) + 1) < 32'(m_len));
        b.d = i_axis_tdata; b.l = last; b.u = !m_inpkt;
        q.push_back(b);
        if (short_p) m_err = 1'b1;
        if (last) begin
          m_inpkt = 1'b0; m_pos = '0;
        end else begin
          m_inpkt = 1'b1; m_pos = m_pos + 16'd1;
        end
      end
      if (i_cnt_clear) begin
        nxt_cnt = '0;
        m_err   = 1'b0;
      end
      m_cnt = nxt_cnt;
      m_rdy = i_enable && (q.size() < 2);
    end
  end

  // ---------------- downstream ready generator ----------------
  // 0: always ready, 1: pattern 1,0,0,1, 2: random ready and enable, 3: manual
  int tmode = 0;
  int pidx  = 0;
  always @(posedge clk) begin
    #1;
    case (tmode)
      0: begin i_axis_tready = 1'b1; pidx = 0; end
      1: begin
        i_axis_tready = (pidx == 0) || (pidx == 3);
        pidx = (pidx + 1) % 4;
      end
      2: begin
        i_axis_tready = ($urandom_range(0, 9) < 7);
        i_enable      = ($urandom_range(0, 9) < 8);
        pidx = 0;
      end
      default: pidx = 0;
    endcase
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_beat(input logic [31:0] d, input logic l);
    int n;
    i_axis_tvalid = 1'b1;
    i_axis_tdata  = d;
    i_axis_tlast  = l;
    n = 0;
    forever begin
      @(negedge clk);
      if (o_axis_tready) break;
      n++;
      if (n > 500) begin
        check("accept_timeout", 32'(o_axis_tready), 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send_pkt(input int n, input logic [31:0] base, input logic end_last);
    for (int i = 0; i < n; i++) begin
      send_beat(base + 32'(i), end_last && (i == n - 1));
    end
    i_axis_tvalid = 1'b0;
    i_axis_tlast  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || o_axis_tvalid) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 1000) check("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic clear_counts();
    i_cnt_clear = 1'b1;
    @(posedge clk); #1;
    i_cnt_clear = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1; i_enable = 1'b0; i_pkt_len = '0; i_cnt_clear = 1'b0;
    i_axis_tuser = 1'b0; i_axis_tvalid = 1'b0; i_axis_tlast = 1'b0;
    i_axis_tdata = '0; i_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 32'(o_axis_tvalid), 32'd0);
    check("rst_tready", 32'(o_axis_tready), 32'd0);
    check("rst_count", o_pkt_count, 32'd0);
    rst = 1'b0; i_enable = 1'b1;

    // Basic framing, length 4, with 1-cycle latency on the first beat
    i_pkt_len = 16'd4;
    send_beat(32'h10, 1'b0);
    check("lat_tvalid", 32'(o_axis_tvalid), 32'd1);
    check("lat_tdata", o_axis_tdata, 32'h10);
    check("lat_tuser", 32'(o_axis_tuser), 32'd1);
    for (int i = 1; i < 8; i++) send_beat(32'h10 + 32'(i), 1'b0);
    i_axis_tvalid = 1'b0;
    drain();
    check("t1_count", o_pkt_count, 32'd2);

    // Backpressure, length 3, downstream ready 1,0,0,1
    tmode = 1;
    i_pkt_len = 16'd3;
    send_pkt(6, 32'h20, 1'b0);
    drain();
    tmode = 0;
    check("t2_count", o_pkt_count, 32'd4);

    // Short then long packet with length 5
    clear_counts();
    i_pkt_len = 16'd5;
    send_pkt(3, 32'h30, 1'b1);
    send_pkt(7, 32'h40, 1'b1);
    drain();
    check("t3_short_err", 32'(o_short_err), 32'd1);
    check("t3_count", o_pkt_count, 32'd3);

    // Passthrough then length 1
    clear_counts();
    i_pkt_len = 16'd0;
    send_pkt(2, 32'h50, 1'b1);
    send_pkt(6, 32'h60, 1'b1);
    i_pkt_len = 16'd1;
    send_pkt(4, 32'h70, 1'b0);
    drain();
    check("t4_short_err", 32'(o_short_err), 32'd0);
    check("t4_count", o_pkt_count, 32'd6);

    // Enable stall with a mid-packet length change
    clear_counts();
    i_pkt_len = 16'd4;
    send_pkt(2, 32'h80, 1'b0);
    i_enable  = 1'b0;
    i_pkt_len = 16'd2;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("t5_stall_tready", 32'(o_axis_tready), 32'd0);
    end
    check("t5_stall_idx", 32'(o_beat_index), 32'd2);
    i_enable = 1'b1;
    send_pkt(2, 32'h82, 1'b0);
    send_pkt(2, 32'h90, 1'b0);
    drain();
    check("t5_count", o_pkt_count, 32'd2);

    // Reset mid-packet with beats in flight
    tmode = 3;
    i_axis_tready = 1'b0;
    i_pkt_len = 16'd4;
    send_pkt(2, 32'hA0, 1'b0);
    rst = 1'b1;
    #1;
    check("arst_tvalid", 32'(o_axis_tvalid), 32'd0);
    check("arst_tready", 32'(o_axis_tready), 32'd0);
    check("arst_tlast", 32'(o_axis_tlast), 32'd0);
    check("arst_tuser", 32'(o_axis_tuser), 32'd0);
    check("arst_tdata", o_axis_tdata, 32'd0);
    check("arst_idx", 32'(o_beat_index), 32'd0);
    check("arst_count", o_pkt_count, 32'd0);
    check("arst_err", 32'(o_short_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tmode = 0;
    send_pkt(4, 32'hB0, 1'b0);
    drain();
    check("t6_count", o_pkt_count, 32'd1);

    // Clear coinciding with a tlast take
    tmode = 3;
    i_axis_tready = 1'b0;
    i_pkt_len = 16'd1;
    send_pkt(1, 32'hC0, 1'b0);
    i_axis_tready = 1'b1;
    i_cnt_clear   = 1'b1;
    @(posedge clk); #1;
    i_cnt_clear = 1'b0;
    check("t7_clear_wins", o_pkt_count, 32'd0);
    tmode = 0;
    drain();

    // Randomized traffic, lengths and enable
    tmode = 2;
    for (int p = 0; p < 40; p++) begin
      int n;
      i_pkt_len = 16'($urandom_range(0, 5));
      n = $urandom_range(1, 8);
      for (int b = 0; b < n; b++) begin
        if ($urandom_range(0, 7) == 0) i_pkt_len = 16'($urandom_range(0, 5));
        send_beat($urandom, (b == n - 1) && ($urandom_range(0, 3) != 0));
        if ($urandom_range(0, 3) == 0) begin
          i_axis_tvalid = 1'b0;
          @(posedge clk); #1;
        end
      end
      i_axis_tvalid = 1'b0;
      i_axis_tlast  = 1'b0;
    end
    tmode = 0;
    i_enable = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axis_packetizer.md
Name: axis_packetizer

Overview:
- Sits directly downstream of the FIFO interconnect's sink AXI-Stream port and directly upstream of the DMA S2MM channel.
- Re-frames the outgoing beat stream into packets of a programmed length, so the DMA sees a deterministic TLAST independent of FIFO occupancy.
- Marks start-of-packet on TUSER, counts beats and packets, and flags upstream TLASTs that arrive early.
- Full-throughput registered stage with a one-entry skid buffer.

Parameters:
- AXIS_DATA_WIDTH, 32, width of TDATA on both stream ports.
- LEN_WIDTH, 16, width of the packet-length input and the in-packet beat counter.
- CNT_WIDTH, 32, width of the packet counter.

Ports:
- clk  input  1  single clock for all logic.
- rst  input  1  asynchronous, active-high reset.
- i_enable  input  1  1 = accept input beats; 0 = stall input, drain buffered beats.
- i_pkt_len  input  LEN_WIDTH  beats per packet; sampled on the first beat of each packet; 0 = passthrough mode.
- i_cnt_clear  input  1  synchronous clear of o_pkt_count and o_short_err.
- i_axis_tuser  input  1  upstream TUSER, ignored.
- i_axis_tvalid  input  1  upstream valid.
- o_axis_tready  output  1  upstream ready.
- i_axis_tlast  input  1  upstream last.
- i_axis_tdata  input  AXIS_DATA_WIDTH  upstream data.
- o_axis_tuser  output  1  1 on the first beat of each output packet.
- o_axis_tvalid  output  1  downstream valid.
- i_axis_tready  input  1  downstream ready.
- o_axis_tlast  output  1  downstream last.
- o_axis_tdata  output  AXIS_DATA_WIDTH  downstream data.
- o_beat_index  output  LEN_WIDTH  index of the next input beat within the current packet.
- o_pkt_count  output  CNT_WIDTH  count of packets completed at the output.
- o_short_err  output  1  sticky flag: upstream TLAST arrived before i_pkt_len beats.

Behaviour:
- Reset (asynchronous, active-high): all outputs are 0, the skid buffer is empty, the FSM is in IDLE, and the latched length is 0.
- Accept rule: an input beat is accepted when i_axis_tvalid & o_axis_tready. An output beat is taken when o_axis_tvalid & i_axis_tready.
- o_axis_tready is registered: it equals i_enable & ~skid_full.
- Datapath: output register plus one skid register.
  - Latency from input acceptance to o_axis_tvalid is 1 cycle.
  - Sustained throughput is 1 beat per clock when i_axis_tready stays high.
  - If the output register is full and not taken while a beat is accepted, that beat goes to the skid register and o_axis_tready drops on the next cycle.
  - When the output is taken, the skid entry moves to the output register, and o_axis_tready re-asserts the cycle after the skid empties.
- Output stability: o_axis_tdata, o_axis_tlast and o_axis_tuser are stable while o_axis_tvalid=1 and i_axis_tready=0. o_axis_tvalid never drops without a take.
- FSM:
  - IDLE: o_beat_index=0. On an accepted beat: latch len_q = i_pkt_len, tag the beat tuser=1, then either emit tlast or move to IN_PKT.
  - IN_PKT: each accepted beat increments o_beat_index. The beat is tagged tlast=1, and the FSM returns to IDLE, when:
    - (len_q != 0) and beat index == len_q-1, or
    - input tlast = 1.
- Length modes:
  - len_q == 1: every beat carries tuser=1 and tlast=1.
  - len_q == 0 (passthrough): tlast mirrors the input, the beat counter still runs and wraps modulo 2^LEN_WIDTH, and o_short_err is never set.
- Short packet: input tlast at beat index < len_q-1 terminates the packet with tlast=1 and sets o_short_err=1.
- Long packet: an input packet longer than len_q is split. tlast is forced at len_q-1, and the next beat starts a new packet with tuser=1. No error is raised.
- Changes to i_pkt_len mid-packet have no effect until the next IDLE acceptance.
- o_pkt_count increments on each output beat taken with tlast=1 and wraps at 2^CNT_WIDTH.
- Simultaneous events: when i_cnt_clear coincides with an increment or an error, the clear wins.
- i_enable deassert:
  - o_axis_tready goes to 0 on the next cycle.
  - A beat accepted in the same cycle is still processed.
  - Buffered beats continue to drain.
  - FSM state and beat index are held, so the packet resumes on re-enable.
- Reset mid-packet: in-flight beats are discarded, no partial tlast is emitted, and the next accepted beat starts a new packet.

Test Plan:
- Basic framing: i_pkt_len=4, 8 continuous beats 0x10..0x17 with downstream ready=1. Output tlast on 0x13 and 0x17, tuser on 0x10 and 0x14, o_pkt_count=2, latency 1 cycle.
- Backpressure: i_pkt_len=3, 6 beats, i_axis_tready toggling 1,0,0,1 repeating. The data order is preserved, o_axis_tready drops only when the skid fills, no beat is lost or duplicated, and tlast lands on the 3rd and 6th beats.
- Short and long packets: i_pkt_len=5, input packet A of 3 beats with tlast, then packet B of 7 beats with tlast.
  - A: tlast on its 3rd beat and o_short_err=1.
  - B: split 5+2 with tlast on its 5th and 7th beats.
  - Final o_pkt_count=3.
- Passthrough and length 1:
  - i_pkt_len=0, packets of 2 and 6 beats: tlast on input tlast positions only.
  - i_pkt_len=1: every beat has tuser=1 and tlast=1.
- Enable and mid-packet length change: i_pkt_len=4, 2 beats accepted, then i_enable=0 for 5 cycles while i_pkt_len is set to 2, then re-enable. o_axis_tready=0 during the stall, and the packet completes with tlast on its 4th beat. The next packet uses length 2.
- Reset and clear:
  - rst asserted after 2 of 4 beats: all outputs are 0 immediately, with no clock edge needed, and a fresh 4-beat packet frames correctly.
  - i_cnt_clear on the same cycle as a tlast take leaves o_pkt_count=0.
